obstacle_runner: RTL and testbench

- Responder end of the obstacle sequencing handshake.
- Receives the current obstacle code and a one-cycle "next code valid" strobe from the sequencer (the sequencer's done_out).
- Plays that obstacle through three frame-timed phases: warning, active and gap.
- At the end it returns a one-cycle done pulse so the sequencer advances to the next code.
- Its outputs drive the obstacle renderers and collision logic.

---
 rtl/obstacle_pkg.sv | 22 ++
 rtl/obstacle_runner_if.sv | 31 +++
 rtl/obstacle_phase_timer.sv | 33 +++
 rtl/obstacle_runner.sv | 125 ++++++++++++
 tb/tb_obstacle_runner.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/obstacle_pkg.sv
// Shared obstacle definitions: code width, default phase lengths and the
// runner FSM state encoding, used by the sequencer, renderers and runner.
package obstacle_pkg;

  localparam int OBS_NUM_BITS     = 3;
  localparam int OBS_CNT_W        = 10;
  localparam int OBS_WARN_FRAMES  = 30;
  localparam int OBS_ACTIVE_BASE  = 120;
  localparam int OBS_ACTIVE_STEP  = 15;
  localparam int OBS_GAP_FRAMES   = 10;
  localparam int OBS_STATE_W      = 3;

  typedef logic [OBS_NUM_BITS-1:0] obs_code_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WARN      = 3'd1;
  localparam logic [2:0] ST_ACTIVE    = 3'd2;
  localparam logic [2:0] ST_GAP       = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_WAIT_CODE = 3'd5;

endpackage

// File: rtl/obstacle_runner_if.sv
// Sequencer <-> runner signals; the runner sits on the slave modport.
interface obstacle_runner_if
  import obstacle_pkg::*;
#(
  parameter int NUM_BITS = OBS_NUM_BITS,
  parameter int CNT_W    = OBS_CNT_W
);
  // code_valid is a one-cycle strobe with no ready: it is taken only when the
  // runner is in WAIT_CODE, and any other arrival sets the sticky protocol_err.
  logic                frame_tick;
  logic                play_selected;
  logic                code_valid;
  logic [NUM_BITS-1:0] obstacle_code_in;
  logic                done;
  logic [NUM_BITS-1:0] code_out;
  logic                warn;
  logic                active;
  logic [CNT_W-1:0]    progress;
  logic                protocol_err;
  logic [2:0]          state_dbg;

  modport master (
    output frame_tick, play_selected, code_valid, obstacle_code_in,
    input  done, code_out, warn, active, progress, protocol_err, state_dbg
  );

  modport slave (
    input  frame_tick, play_selected, code_valid, obstacle_code_in,
    output done, code_out, warn, active, progress, protocol_err, state_dbg
  );
endinterface

// File: rtl/obstacle_phase_timer.sv
// Frame counter for one obstacle phase: cleared by the FSM, advanced by
// frame_tick, flags the tick on which the terminal count is reached.
module obstacle_phase_timer #(
  parameter int CNT_W  = 10,
  parameter int TERM_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              tick,
  input  logic [TERM_W-1:0] term,
  output logic [CNT_W-1:0]  cnt,
  output logic              last
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && tick)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign last = en && tick && (TERM_W'(cnt_q) == term);
endmodule

// File: rtl/obstacle_runner.sv
// Plays one obstacle code through WARN / ACTIVE / GAP frame phases and
// answers the sequencer with a single-cycle done pulse.
module obstacle_runner
  import obstacle_pkg::*;
#(
  parameter int NUM_BITS    = OBS_NUM_BITS,
  parameter int CNT_W       = OBS_CNT_W,
  parameter int WARN_FRAMES = OBS_WARN_FRAMES,
  parameter int ACTIVE_BASE = OBS_ACTIVE_BASE,
  parameter int ACTIVE_STEP = OBS_ACTIVE_STEP,
  parameter int GAP_FRAMES  = OBS_GAP_FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  obstacle_runner_if.slave  bus
);
  localparam int TW = CNT_W + NUM_BITS;

  logic [2:0]          state_q, state_d;
  logic [NUM_BITS-1:0] code_q, code_d;
  logic [TW-1:0]       dur_m1_q, dur_m1_d;
  logic                play_prev_q;
  logic                err_q, err_d;
  logic                warn_q, warn_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic                in_phase, t_clr, t_last;
  logic [TW-1:0]       t_term;
  logic [CNT_W-1:0]    t_cnt;

  // Last ACTIVE count, kept at full width so large codes never wrap.
  function automatic logic [TW-1:0] active_last(input logic [NUM_BITS-1:0] code);
    return TW'(ACTIVE_BASE) + TW'(ACTIVE_STEP) * TW'(code) - TW'(1);
  endfunction

  assign in_phase = (state_q == ST_WARN) || (state_q == ST_ACTIVE) || (state_q == ST_GAP);

  always_comb begin
    t_term = '0;
    case (state_q)
      ST_WARN:   t_term = TW'(WARN_FRAMES - 1);
      ST_ACTIVE: t_term = dur_m1_q;
      ST_GAP:    t_term = TW'(GAP_FRAMES - 1);
      default:   t_term = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    dur_m1_d = dur_m1_q;
    err_d    = err_q;
    if (!bus.play_selected) begin
      state_d = ST_IDLE;
      code_d  = '0;
      err_d   = 1'b0;
    end else begin
      if (bus.code_valid && (state_q != ST_WAIT_CODE))
        err_d = 1'b1;
      case (state_q)
        ST_IDLE: if (!play_prev_q) begin
          code_d   = bus.obstacle_code_in;
          dur_m1_d = active_last(bus.obstacle_code_in);
          state_d  = ST_WARN;
        end
        ST_WARN:   if (t_last) state_d = ST_ACTIVE;
        ST_ACTIVE: if (t_last) state_d = ST_GAP;
        ST_GAP:    if (t_last) state_d = ST_DONE;
        ST_DONE:   state_d = ST_WAIT_CODE;
        ST_WAIT_CODE: if (bus.code_valid) begin
          code_d   = bus.obstacle_code_in;
          dur_m1_d = active_last(bus.obstacle_code_in);
          state_d  = ST_WARN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Any phase change (including entry) drops the tick of that cycle.
    t_clr    = (state_d != state_q) || !in_phase;
    warn_d   = (state_d == ST_WARN);
    active_d = (state_d == ST_ACTIVE);
    done_d   = (state_d == ST_DONE);
  end

  obstacle_phase_timer #(.CNT_W(CNT_W), .TERM_W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (t_clr),
    .en   (in_phase),
    .tick (bus.frame_tick),
    .term (t_term),
    .cnt  (t_cnt),
    .last (t_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      dur_m1_q    <= '0;
      play_prev_q <= 1'b0;
      err_q       <= 1'b0;
      warn_q      <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      dur_m1_q    <= dur_m1_d;
      play_prev_q <= bus.play_selected;
      err_q       <= err_d;
      warn_q      <= warn_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  assign bus.done         = done_q;
  assign bus.code_out     = code_q;
  assign bus.warn         = warn_q;
  assign bus.active       = active_q;
  assign bus.progress     = t_cnt;
  assign bus.protocol_err = err_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_obstacle_runner.sv
// Randomized closed-loop bench for obstacle_runner against a phase/tick-count
// reference model, with a scoreboard of the codes the sequencer issues.
module tb_obstacle_runner;
  import obstacle_pkg::*;

  localparam int NB = 3;
  localparam int CW = 10;
  localparam int WF = 2;
  localparam int AB = 4;
  localparam int AS = 1;
  localparam int GF = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obstacle_runner_if #(.NUM_BITS(NB), .CNT_W(CW)) bus ();

  obstacle_runner #(
    .NUM_BITS(NB), .CNT_W(CW), .WARN_FRAMES(WF),
    .ACTIVE_BASE(AB), .ACTIVE_STEP(AS), .GAP_FRAMES(GF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int tick_ph  = 0;

  // Reference model: phase 0 idle, 1 warn, 2 active, 3 gap, 4 done, 5 wait.
  int m_phase = 0;
  int m_len   = 0;
  int m_left  = 0;
  int m_code  = 0;
  bit m_err   = 1'b0;
  bit m_prev  = 1'b0;

  // Sequencer model and scoreboard of codes expected at each done.
  int seq_code = 0;
  int pend     = -1;
  logic [NB-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [2:0] st_of(input int p);
    case (p)
      1:       return ST_WARN;
      2:       return ST_ACTIVE;
      3:       return ST_GAP;
      4:       return ST_DONE;
      5:       return ST_WAIT_CODE;
      default: return ST_IDLE;
    endcase
  endfunction

  task automatic model_enter(input int p);
    m_phase = p;
    case (p)
      1:       m_len = WF;
      2:       m_len = AB + AS * m_code;
      3:       m_len = GF;
      default: m_len = 0;
    endcase
    m_left = m_len;
  endtask

  task automatic model_step(input bit r, input bit play, input bit tick, input bit cv, input int cin);
    if (r || !play) begin
      m_code = 0;
      m_err  = 1'b0;
      m_prev = 1'b0;
      model_enter(0);
      return;
    end
    if (cv && m_phase != 5) m_err = 1'b1;
    case (m_phase)
      0: if (!m_prev) begin m_code = cin; model_enter(1); end
      1, 2, 3: if (tick) begin
        m_left--;
        if (m_left == 0) model_enter(m_phase + 1);
      end
      4: model_enter(5);
      5: if (cv) begin m_code = cin; model_enter(1); end
      default: model_enter(0);
    endcase
    m_prev = 1'b1;
  endtask

  task automatic cycle();
    bus.frame_tick = ((cyc + tick_ph) % 4) == 0;
    @(posedge clk);
    model_step(rst, bus.play_selected, bus.frame_tick, bus.code_valid, int'(bus.obstacle_code_in));
    cyc++;
    #1;
    check("warn",     32'(bus.warn),         32'(m_phase == 1));
    check("active",   32'(bus.active),       32'(m_phase == 2));
    check("done",     32'(bus.done),         32'(m_phase == 4));
    check("code_out", 32'(bus.code_out),     32'(m_code));
    check("progress", 32'(bus.progress),     32'(m_len - m_left));
    check("err",      32'(bus.protocol_err), 32'(m_err));
    check("state",    32'(bus.state_dbg),    32'(st_of(m_phase)));
  endtask

  task automatic start_play();
    seq_code = 0;
    pend     = -1;
    bus.obstacle_code_in = '0;
    bus.play_selected    = 1'b1;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic run_loop(input int n_obs, input int stop_phase, input int stop_prog, input bit inject);
    int  seen      = 0;
    int  budget    = 0;
    bit  stopped   = 1'b0;
    bit  injected  = 1'b0;
    bit  check_inj = 1'b0;
    while (seen < n_obs && !stopped && budget < 3000) begin
      cycle();
      budget++;
      if (check_inj) begin
        check("inj_err_set",   32'(bus.protocol_err), 1);
        check("inj_code_kept", 32'(bus.code_out),     5);
        check_inj = 1'b0;
      end
      bus.code_valid = 1'b0;
      if (bus.done) begin
        seen++;
        if (exp_q.size() == 0) check("sb_depth", 32'(exp_q.size()), 1);
        else                   check("sb_code", 32'(bus.code_out), 32'(exp_q.pop_front()));
        seq_code = (seq_code + 1) % 8;
        bus.obstacle_code_in = NB'(seq_code);
        exp_q.push_back(NB'(seq_code));
        pend = $urandom_range(0, 2);
      end else if (pend == 0) begin
        bus.code_valid = 1'b1;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (inject && !injected && m_phase == 2 && m_code == 5 && (m_len - m_left) == 1) begin
        bus.code_valid = 1'b1;
        injected  = 1'b1;
        check_inj = 1'b1;
      end
      if (stop_phase >= 0 && m_phase == stop_phase && (m_len - m_left) == stop_prog)
        stopped = 1'b1;
    end
    if (budget >= 3000) check("loop_budget", 32'(budget), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.play_selected    = 1'b0;
    bus.code_valid       = 1'b0;
    bus.obstacle_code_in = '0;
    bus.frame_tick       = 1'b0;
    repeat (3) cycle();
    check("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    tick_ph = $urandom_range(0, 3);
    repeat ($urandom_range(1, 5)) cycle();

    // Code 0 from play rise, then codes 1..7 and wrap to 0, one stray code_valid in ACTIVE.
    start_play();
    run_loop(9, -1, 0, 1'b1);

    // Drop play mid-ACTIVE at progress 2.
    run_loop(100, 2, 2, 1'b0);
    bus.play_selected = 1'b0;
    bus.code_valid    = 1'b0;
    cycle();
    check("drop_state", 32'(bus.state_dbg),    32'(ST_IDLE));
    check("drop_err",   32'(bus.protocol_err), 0);
    check("drop_done",  32'(bus.done),         0);
    repeat (3) cycle();

    // Restart on a cycle whose frame_tick coincides with WARN entry.
    tick_ph = (4 - (cyc % 4)) % 4;
    start_play();
    cycle();
    check("entry_warn",     32'(bus.warn),     1);
    check("entry_progress", 32'(bus.progress), 0);
    run_loop(2, -1, 0, 1'b0);

    // Reset during GAP together with code_valid.
    run_loop(100, 3, 0, 1'b0);
    rst = 1'b1;
    bus.code_valid = 1'b1;
    cycle();
    check("gap_rst_err",   32'(bus.protocol_err), 0);
    check("gap_rst_done",  32'(bus.done),         0);
    check("gap_rst_state", 32'(bus.state_dbg),    32'(ST_IDLE));
    rst = 1'b0;
    bus.code_valid = 1'b0;

    // Free-running random traffic.
    for (int i = 0; i < 600; i++) begin
      rst                  = ($urandom_range(0, 99) == 0);
      bus.code_valid       = ($urandom_range(0, 7) == 0);
      bus.obstacle_code_in = NB'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) bus.play_selected = ~bus.play_selected;
      if ($urandom_range(0, 99) == 0) tick_ph = $urandom_range(0, 3);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
